// File: rtl/pm_arbiter.sv
// Two-port program-memory read arbiter: fetch (port 0) vs. vector/data load (port 1).
// Keeps an in-order tag queue so each memory response is routed back to the port that issued it.
module pm_arbiter #(
    parameter int XLEN       = 32,
    parameter int MAX_OUTST  = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           req_i,
    input  logic [1:0][XLEN-1:0] addr_i,
    output logic [1:0]           gnt_o,
    output logic [1:0]           rvalid_o,
    output logic [XLEN-1:0]      rdata_o,
    input  logic                 flush_i,
    output logic                 mem_req_o,
    output logic [XLEN-1:0]      mem_addr_o,
    input  logic                 mem_ready_i,
    input  logic                 mem_rvalid_i,
    input  logic [XLEN-1:0]      mem_rdata_i,
    output logic                 err_o
);

    localparam int CW = $clog2(MAX_OUTST + 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [MAX_OUTST-1:0] id_q, id_d;
    logic [MAX_OUTST-1:0] disc_q, disc_d;
    logic                 lp_q, lp_d;
    logic                 err_q, err_d;

    logic winner;
    logic accept;
    logic empty;
    logic pop;
    int   wr_idx;

    assign empty = (cnt_q == '0);
    assign pop   = mem_rvalid_i & ~empty;

    always_comb begin
        winner = req_i[1];
        if (req_i == 2'b11) begin
            winner = (FIXED_PRIO != 0) ? 1'b1 : ~lp_q;
        end
    end

    assign mem_req_o  = (|req_i) & (cnt_q < CW'(MAX_OUTST));
    assign mem_addr_o = addr_i[winner];
    assign accept     = mem_req_o & mem_ready_i;
    assign gnt_o      = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;

    // Routing uses the stored discard bit of the head entry.
    assign rvalid_o[0] = pop & ~id_q[0] & ~disc_q[0];
    assign rvalid_o[1] = pop &  id_q[0] & ~disc_q[0];
    assign rdata_o     = mem_rdata_i;
    assign err_o       = err_q;

    // Queue is kept head-at-index-0: a pop shifts down, a push lands just past the last live entry.
    always_comb begin
        id_d   = id_q;
        disc_d = disc_q;
        lp_d   = lp_q;
        err_d  = err_q | (mem_rvalid_i & empty);
        wr_idx = int'(cnt_q) - (pop ? 1 : 0);

        if (flush_i) begin
            disc_d = disc_q | ~id_q;
        end

        if (pop) begin
            for (int i = 0; i < MAX_OUTST - 1; i++) begin
                id_d[i]   = id_d[i+1];
                disc_d[i] = disc_d[i+1];
            end
        end

        if (accept) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                if (i == wr_idx) begin
                    id_d[i]   = winner;
                    disc_d[i] = flush_i & ~winner;
                end
            end
            lp_d = winner;
        end

        cnt_d = cnt_q + CW'(accept) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            id_q   <= '0;
            disc_q <= '0;
            lp_q   <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            id_q   <= id_d;
            disc_q <= disc_d;
            lp_q   <= lp_d;
            err_q  <= err_d;
        end
    end

endmodule
